uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART byte serializer among NUM_CH byte producers, e.g. telemetry, debug log and command echo.
- Latches the winning byte and issues a one-cycle begin pulse to the serializer.
- Holds the byte stable for the whole frame, then tracks the serializer's busy flag until the frame ends.
- Sits between the producers and the serializer's begin/data/busy interface.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- CH_BITS, 2, width of the channel index; must satisfy 2**CH_BITS >= NUM_CH.
- START_TIMEOUT, 8, cycles to wait for the serializer busy flag to rise after begin before aborting.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  grant enable; when low no new grant is made, and a frame already in flight completes.
- req  in  NUM_CH  per-channel request level; hold high with data stable until ack.
- req_data  in  8*NUM_CH  channel i byte on bits [8i+7:8i].
- ack  out  NUM_CH  one-cycle pulse; the byte of channel i was captured.
- tx_begin  out  1  begin pulse to the serializer.
- tx_data  out  8  byte to the serializer; constant from grant until the next grant.
- tx_busy  in  1  serializer busy flag.
- grant_id  out  CH_BITS  channel of the current or most recent grant.
- arb_busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  one-cycle pulse when the serializer never went busy.

Behaviour:
- Reset values: ack=0, tx_begin=0, tx_data=8'h00, grant_id=0, err_timeout=0, state=IDLE, last=NUM_CH-1, so channel 0 has top priority after reset.
- All outputs are registered.
- States are IDLE, START, WAIT_BUSY, WAIT_DONE; arb_busy = (state != IDLE).
- IDLE:
  - Grant condition: en=1, |req=1 and tx_busy=0.
  - Winner: first requesting channel scanning last+1, last+2, ... with modulo-NUM_CH wrap.
  - On grant, next edge: tx_data <= winner's byte, ack[winner] <= 1, grant_id <= winner, last <= winner, state <= START.
- START: tx_begin=1 for exactly this one cycle; ack returns to 0; next state is WAIT_BUSY with the timeout counter cleared.
- WAIT_BUSY:
  - tx_begin=0.
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter; when counter == START_TIMEOUT-1, pulse err_timeout for one cycle and return to IDLE.
  - A timed-out byte is dropped; its ack was already given.
- WAIT_DONE: remain while tx_busy=1; on tx_busy=0, go to IDLE.
- The block never asserts tx_begin during the serializer's stop bit. Back-to-back frames therefore have one idle-high bit-time gap plus 2 clocks of arbitration.
- Grant latency: req high in IDLE at edge t gives ack and tx_data at t+1 and tx_begin at t+1..t+2. Minimum spacing between grants is the frame time plus 3 cycles.
- tx_data does not change between grants; the serializer relies on this because it samples data bit by bit.
- A requester may present its next byte the cycle after ack, keeping req high. Lowering req before ack withdraws the request without side effects.
- A req bit for a channel index >= NUM_CH does not exist; req_data bits outside the 8*NUM_CH range do not exist.
- Simultaneous requests: exactly one ack per grant. Under continuous load every channel is granted once per NUM_CH grants.
- en falling in START, WAIT_BUSY or WAIT_DONE does not abort; the block finishes and then stays in IDLE.
- rst mid-frame: state returns to IDLE and tx_begin drops. The serializer is not reset by this block; the IDLE grant condition (tx_busy=0) prevents a new begin until the old frame ends.
- tx_busy high in IDLE with no frame of ours (e.g. after reset) stalls granting and is not an error.

Test Plan:
- Single request: req=4'b0001, byte 8'hA5, tx_busy modelled 2 cycles after begin -> ack[0] pulses once, tx_begin high for 1 cycle, tx_data=8'hA5 held until tx_busy falls, then arb_busy=0.
- All four channels request continuously with bytes 8'h10..8'h13 -> grant order 0,1,2,3,0,1...; each ack is one cycle; no begin is issued while tx_busy=1.
- Fairness after partial grant: last=1, req=4'b1011 -> next grant goes to 3, then 0, then 1.
- Timeout: tx_busy held 0 with START_TIMEOUT=8 -> err_timeout pulses exactly 8 cycles after WAIT_BUSY entry; returns to IDLE; the next grant works normally.
- en=0 while req=4'b0100 -> no ack and no begin; en=1 -> grant to 2 within 1 cycle. en dropped during WAIT_DONE -> frame completes, then no further grant.
- rst asserted during WAIT_DONE with tx_busy=1 -> outputs at reset values next cycle; a pending req is granted only after tx_busy goes low.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the producer request bus and the serializer begin/data/busy link
// that pass through the UART transmit arbiter.
//
// Signals:
//   req       producers -> arbiter   per-channel request level
//   req_data  producers -> arbiter   channel i byte on bits [8i+7:8i]
//   ack       arbiter -> producers   one-cycle capture pulse per channel
//   tx_begin  arbiter -> serializer  one-cycle frame start pulse
//   tx_data   arbiter -> serializer  byte held stable for the whole frame
//   tx_busy   serializer -> arbiter  frame in progress
//
// Modports:
//   slave   the arbiter side
//   master  the environment side (producers plus serializer)
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_CH = 4
) ();
  logic [NUM_CH-1:0]   req;
  logic [8*NUM_CH-1:0] req_data;
  logic [NUM_CH-1:0]   ack;
  logic                tx_begin;
  logic [7:0]          tx_data;
  logic                tx_busy;

  modport slave (
    input  req,
    input  req_data,
    input  tx_busy,
    output ack,
    output tx_begin,
    output tx_data
  );

  modport master (
    output req,
    output req_data,
    output tx_busy,
    input  ack,
    input  tx_begin,
    input  tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one UART byte serializer among NUM_CH byte
// producers. The winning byte is latched, a one-cycle begin pulse is issued,
// and the byte is held until the serializer's busy flag shows the frame ended.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   en           grant enable; frames already in flight always complete
//   bus          uart_tx_arbiter_if.slave (req/req_data/ack, tx_begin/
//                tx_data/tx_busy)
//   grant_id     channel of the current or most recent grant
//   arb_busy     high whenever the arbiter is not idle
//   err_timeout  one-cycle pulse when the serializer never went busy
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_CH        = 4,
  parameter int CH_BITS       = 2,
  parameter int START_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  uart_tx_arbiter_if.slave    bus,
  output logic [CH_BITS-1:0]  grant_id,
  output logic                arb_busy,
  output logic                err_timeout
);

  localparam int CNT_BITS = $clog2(START_TIMEOUT + 1);
  localparam int IDX_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state_r;
  logic [CH_BITS-1:0]  last_r;
  logic [CH_BITS-1:0]  grant_id_r;
  logic [NUM_CH-1:0]   ack_r;
  logic                tx_begin_r;
  logic [7:0]          tx_data_r;
  logic                err_timeout_r;
  logic                arb_busy_r;
  logic [CNT_BITS-1:0] cnt_r;

  logic [2*NUM_CH-1:0] req2_s;
  logic [NUM_CH-1:0]   rot_s;
  logic                found_s;
  int                  off_s;
  logic [CH_BITS-1:0]  win_s;
  logic [7:0]          win_data_s;
  logic [NUM_CH-1:0]   win_onehot_s;
  logic                grant_s;

  // Two copies of req side by side let a plain shift implement the modulo
  // wrap: bit j of rot_s is the request of channel (last+1+j) mod NUM_CH.
  assign req2_s = {bus.req, bus.req};
  assign rot_s  = NUM_CH'(req2_s >> (int'(last_r) + 1));

  // Round-robin pick: lowest set bit of the rotated vector is the winner offset.
  always_comb begin
    found_s = 1'b0;
    off_s   = 0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (rot_s[IDX_BITS'(j)]) begin
        found_s = 1'b1;
        off_s   = j;
      end else begin
        off_s   = off_s;
      end
    end
    win_s        = CH_BITS'((int'(last_r) + 1 + off_s) % NUM_CH);
    win_data_s   = 8'(bus.req_data >> {win_s, 3'b000});
    win_onehot_s = NUM_CH'(1) << win_s;
  end

  // A new grant also waits for tx_busy low so a frame left over from before a
  // reset is never overlapped.
  assign grant_s = en && found_s && !bus.tx_busy;

  // Arbitration state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      last_r        <= CH_BITS'(NUM_CH - 1);
      grant_id_r    <= '0;
      ack_r         <= '0;
      tx_begin_r    <= 1'b0;
      tx_data_r     <= 8'h00;
      err_timeout_r <= 1'b0;
      arb_busy_r    <= 1'b0;
      cnt_r         <= '0;
    end else begin
      ack_r         <= '0;
      tx_begin_r    <= 1'b0;
      err_timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            tx_data_r  <= win_data_s;
            ack_r      <= win_onehot_s;
            grant_id_r <= win_s;
            last_r     <= win_s;
            tx_begin_r <= 1'b1;
            arb_busy_r <= 1'b1;
            state_r    <= START;
          end else begin
            arb_busy_r <= 1'b0;
          end
        end
        START: begin
          cnt_r      <= '0;
          arb_busy_r <= 1'b1;
          state_r    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_r <= WAIT_DONE;
          end else if (cnt_r == CNT_BITS'(START_TIMEOUT - 1)) begin
            // Serializer never started: drop the byte, its ack already went out.
            err_timeout_r <= 1'b1;
            arb_busy_r    <= 1'b0;
            state_r       <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_BITS'(1);
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            arb_busy_r <= 1'b0;
            state_r    <= IDLE;
          end else begin
            arb_busy_r <= 1'b1;
          end
        end
        default: begin
          arb_busy_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = ack_r;
  assign bus.tx_begin = tx_begin_r;
  assign bus.tx_data  = tx_data_r;
  assign grant_id     = grant_id_r;
  assign arb_busy     = arb_busy_r;
  assign err_timeout  = err_timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Scoreboard bench: every issued request pushes the expected grant (channel,
// byte, timeout flag) into a queue; an independent monitor pops and compares
// whenever an ack appears and follows the frame until the arbiter goes idle.
// A small serializer model answers tx_begin with a configurable busy pulse.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int NUM_CH        = 4;
  localparam int CH_BITS       = 2;
  localparam int START_TIMEOUT = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [CH_BITS-1:0] grant_id;
  logic               arb_busy;
  logic               err_timeout;

  uart_tx_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

  uart_tx_arbiter #(
    .NUM_CH(NUM_CH),
    .CH_BITS(CH_BITS),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .bus(bus),
    .grant_id(grant_id),
    .arb_busy(arb_busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req_v);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         ch;
    logic [7:0] data;
    bit         to;
  } exp_t;

  exp_t exp_q[$];
  int   last_m;

  // Round-robin rule: first requester after the last winner, wrapping.
  function automatic int rr_pick(input logic [NUM_CH-1:0] mask, input int last);
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (last + k) % NUM_CH;
      if (((mask >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  task automatic expect_grant(input logic [NUM_CH-1:0] mask, input logic [31:0] data, input bit to);
    exp_t e;
    int   w;
    w      = rr_pick(mask, last_m);
    last_m = w;
    e.ch   = w;
    e.data = 8'(data >> (8 * w));
    e.to   = to;
    exp_q.push_back(e);
  endtask

  // ---------------- serializer model ----------------
  int ser_delay = 2;
  int ser_len   = 6;
  bit ser_never = 1'b0;

  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_begin === 1'b1 && !ser_never) begin
        repeat (ser_delay) @(negedge clk);
        bus.tx_busy = 1'b1;
        repeat (ser_len) @(negedge clk);
        bus.tx_busy = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    exp_t cur;
    bit   cur_valid;
    int   begins;
    bit   err_seen;
    cur_valid = 1'b0;
    begins    = 0;
    err_seen  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cur_valid = 1'b0;
      end else begin
        if (bus.ack != '0) begin
          chk("ack_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ack_onehot", 32'(bus.ack), 32'(1 << e.ch));
            chk("grant_id", 32'(grant_id), 32'(e.ch));
            chk("tx_data_at_grant", 32'(bus.tx_data), 32'(e.data));
            cur       = e;
            cur_valid = 1'b1;
            begins    = 0;
            err_seen  = 1'b0;
          end
        end
        if (bus.tx_begin) chk("begin_while_busy", 32'(bus.tx_busy), 32'd0);
        if (err_timeout) chk("err_in_frame", 32'(cur_valid), 32'd1);
        if (cur_valid) begin
          if (bus.tx_begin) begins++;
          if (err_timeout) err_seen = 1'b1;
          if (arb_busy) begin
            chk("tx_data_held", 32'(bus.tx_data), 32'(cur.data));
          end else begin
            chk("begins_per_frame", 32'(begins), 32'd1);
            chk("timeout_flag", 32'(err_seen), 32'(cur.to));
            cur_valid = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle();
    for (int i = 0; i < 300 && (arb_busy !== 1'b0 || bus.tx_busy !== 1'b0); i++) @(negedge clk);
    chk("wait_idle", 32'({arb_busy, bus.tx_busy}), 32'd0);
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 100 && bus.ack == '0; i++) @(negedge clk);
    chk("ack_arrived", 32'(|bus.ack), 32'd1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ack"}, 32'(bus.ack), 32'd0);
    chk({tag, "_tx_begin"}, 32'(bus.tx_begin), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    chk({tag, "_arb_busy"}, 32'(arb_busy), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          seen;
    int          k;
    logic [31:0] data;
    logic [3:0]  mask;
    rst          = 1'b1;
    en           = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    last_m       = NUM_CH - 1;
    repeat (3) @(negedge clk);
    chk_reset_values("por");
    rst = 1'b0;
    @(negedge clk);

    // All channels loaded continuously: expect 0,1,2,3,0,1,2,3.
    ser_delay = 1;
    ser_len   = 4;
    data      = 32'h13121110;
    for (int i = 0; i < 8; i++) expect_grant(4'b1111, data, 1'b0);
    bus.req_data = data;
    bus.req      = 4'b1111;
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    chk("continuous_all_granted", 32'(exp_q.size()), 32'd0);
    bus.req = '0;
    wait_idle();

    // Single request with grant latency and hold checks.
    ser_delay = 2;
    ser_len   = 6;
    expect_grant(4'b0001, 32'h000000A5, 1'b0);
    bus.req_data = 32'h000000A5;
    bus.req      = 4'b0001;
    @(negedge clk);
    chk("single_ack", 32'(bus.ack), 32'd1);
    chk("single_begin", 32'(bus.tx_begin), 32'd1);
    chk("single_data", 32'(bus.tx_data), 32'hA5);
    bus.req = '0;
    @(negedge clk);
    chk("single_ack_drop", 32'(bus.ack), 32'd0);
    chk("single_begin_drop", 32'(bus.tx_begin), 32'd0);
    wait_idle();
    chk("single_data_after_frame", 32'(bus.tx_data), 32'hA5);

    // Fairness: grant channel 1, then 1011 must go 3, 0, 1.
    expect_grant(4'b0010, 32'h0000B100, 1'b0);
    bus.req_data = 32'h0000B100;
    bus.req      = 4'b0010;
    wait_ack();
    bus.req = '0;
    wait_idle();
    data = 32'hC3C2C1C0;
    for (int i = 0; i < 3; i++) expect_grant(4'b1011, data, 1'b0);
    bus.req_data = data;
    bus.req      = 4'b1011;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    chk("fair_all_granted", 32'(exp_q.size()), 32'd0);
    bus.req = '0;
    wait_idle();

    // Timeout: the START cycle is one negedge before WAIT_BUSY is entered,
    // so the pulse shows START_TIMEOUT+1 negedges after the begin is seen.
    ser_never = 1'b1;
    expect_grant(4'b0100, 32'h00770000, 1'b1);
    bus.req_data = 32'h00770000;
    bus.req      = 4'b0100;
    @(negedge clk);
    chk("timeout_begin", 32'(bus.tx_begin), 32'd1);
    bus.req = '0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k++;
      if (err_timeout) break;
    end
    chk("timeout_cycles", 32'(k), 32'(START_TIMEOUT + 1));
    wait_idle();
    ser_never = 1'b0;

    // en low blocks new grants; raising it grants within one cycle.
    en           = 1'b0;
    bus.req_data = 32'h00420000;
    bus.req      = 4'b0100;
    seen         = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | (|bus.ack) | bus.tx_begin;
    end
    chk("en_low_no_grant", 32'(seen), 32'd0);
    expect_grant(4'b0100, 32'h00420000, 1'b0);
    en = 1'b1;
    @(negedge clk);
    chk("en_high_grant", 32'(bus.ack), 32'b0100);
    bus.req = '0;
    wait_idle();

    // en dropped mid-frame: the frame completes, then no further grant.
    ser_len = 10;
    expect_grant(4'b0010, 32'h00005100, 1'b0);
    bus.req_data = 32'h00005100;
    bus.req      = 4'b0010;
    wait_ack();
    bus.req_data = 32'h00005200;
    for (int i = 0; i < 50 && bus.tx_busy == 1'b0; i++) @(negedge clk);
    en = 1'b0;
    wait_idle();
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | (|bus.ack) | bus.tx_begin;
    end
    chk("en_drop_no_regrant", 32'(seen), 32'd0);
    expect_grant(4'b0010, 32'h00005200, 1'b0);
    en = 1'b1;
    wait_ack();
    bus.req = '0;
    wait_idle();

    // Reset during WAIT_DONE with the serializer still busy.
    ser_delay = 1;
    ser_len   = 30;
    expect_grant(4'b0010, 32'h00006600, 1'b0);
    bus.req_data = 32'h00006600;
    bus.req      = 4'b0010;
    wait_ack();
    bus.req = '0;
    for (int i = 0; i < 50 && bus.tx_busy == 1'b0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", 32'(arb_busy), 32'd1);
    rst          = 1'b1;
    bus.req_data = 32'h00727100;
    bus.req      = 4'b0110;
    @(negedge clk);
    chk_reset_values("midrst");
    rst    = 1'b0;
    last_m = NUM_CH - 1;
    expect_grant(4'b0110, 32'h00727100, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 80 && bus.tx_busy == 1'b1; i++) begin
      seen = seen | (|bus.ack);
      @(negedge clk);
    end
    chk("no_grant_while_busy", 32'(seen), 32'd0);
    wait_ack();
    bus.req = '0;
    wait_idle();

    // Randomized rounds against the model.
    for (int r = 0; r < 30; r++) begin
      wait_idle();
      ser_never = ($urandom_range(0, 5) == 0);
      ser_delay = $urandom_range(1, 3);
      ser_len   = $urandom_range(2, 8);
      mask      = 4'($urandom_range(1, 15));
      data      = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      expect_grant(mask, data, ser_never);
      bus.req_data = data;
      bus.req      = mask;
      wait_ack();
      bus.req = '0;
    end
    wait_idle();
    ser_never = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
